// File: rtl/rvb_bextdep_arb.sv
// Round-robin front end sharing one rvb_bextdep unit between two requesters.
// An in-order owner-tag FIFO steers each unit result back to the port that issued it.
module rvb_bextdep_arb #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,

   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [XLEN-1:0]          req0_rs1,
   input  logic [XLEN-1:0]          req0_rs2,
   input  logic [4:0]               req0_ctrl,

   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [XLEN-1:0]          req1_rs1,
   input  logic [XLEN-1:0]          req1_rs2,
   input  logic [4:0]               req1_ctrl,

   output logic                     rsp0_valid,
   input  logic                     rsp0_ready,
   output logic [XLEN-1:0]          rsp0_rd,

   output logic                     rsp1_valid,
   input  logic                     rsp1_ready,
   output logic [XLEN-1:0]          rsp1_rd,

   output logic                     unit_din_valid,
   input  logic                     unit_din_ready,
   output logic [XLEN-1:0]          unit_din_rs1,
   output logic [XLEN-1:0]          unit_din_rs2,
   output logic [4:0]               unit_din_ctrl,

   input  logic                     unit_dout_valid,
   output logic                     unit_dout_ready,
   input  logic [XLEN-1:0]          unit_dout_rd,

   output logic [$clog2(DEPTH):0]   inflight,
   output logic                     proto_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic          ptr_q;
   logic          lock_q;
   logic          lock_id_q;
   logic          err_q;
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          fifo_q [DEPTH];

   logic gid;
   logic gvalid;
   logic full;
   logic empty;
   logic head;
   logic push;
   logic pop;
   logic stall;

   // A presented-but-refused request keeps the grant so the unit sees stable operands.
   always_comb begin
      if (lock_q) begin
         gid = lock_id_q;
      end else if (req0_valid && req1_valid) begin
         gid = ptr_q;
      end else begin
         gid = req1_valid;
      end
   end

   assign gvalid = gid ? req1_valid : req0_valid;
   assign full   = (cnt_q == (AW+1)'(DEPTH));
   assign empty  = (cnt_q == '0);
   assign head   = fifo_q[rd_q];

   assign unit_din_valid = !reset && gvalid && !full;
   assign unit_din_rs1   = gid ? req1_rs1  : req0_rs1;
   assign unit_din_rs2   = gid ? req1_rs2  : req0_rs2;
   assign unit_din_ctrl  = gid ? req1_ctrl : req0_ctrl;

   assign push  = unit_din_valid && unit_din_ready;
   assign stall = unit_din_valid && !unit_din_ready;

   assign req0_ready = push && !gid;
   assign req1_ready = push && gid;

   assign rsp0_valid      = !reset && unit_dout_valid && !empty && !head;
   assign rsp1_valid      = !reset && unit_dout_valid && !empty && head;
   assign rsp0_rd         = unit_dout_rd;
   assign rsp1_rd         = unit_dout_rd;
   assign unit_dout_ready = !reset && !empty && (head ? rsp1_ready : rsp0_ready);

   assign pop = unit_dout_valid && unit_dout_ready;

   assign inflight  = cnt_q;
   assign proto_err = err_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q     <= 1'b0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         err_q     <= 1'b0;
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
      end else begin
         lock_q <= stall;
         if (stall) begin
            lock_id_q <= gid;
         end
         if (push) begin
            ptr_q <= !gid;
            wr_q  <= wr_q + AW'(1);
         end
         if (pop) begin
            rd_q <= rd_q + AW'(1);
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + (AW+1)'(1);
         end else if (!push && pop) begin
            cnt_q <= cnt_q - (AW+1)'(1);
         end
         if (unit_dout_valid && empty) begin
            err_q <= 1'b1;
         end
      end
   end

   // Tag storage needs no reset: occupancy is tracked by cnt_q.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_q[wr_q] <= gid;
      end
   end

endmodule

// File: tb/tb_rvb_bextdep_arb.sv
// Randomized bench for rvb_bextdep_arb: the bench plays the requesters and a
// variable-latency unit, and predicts grants, occupancy and routing from a queue model.
module tb_rvb_bextdep_arb;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned BOUND = 400;
   localparam logic [4:0] CtrlBdep = 5'b10110;
   localparam logic [4:0] CtrlBext = 5'b00110;

   typedef struct {
      logic [31:0] data;
      int          due;
   } uent_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic        r_valid [2];
   logic [31:0] r_rs1   [2];
   logic [31:0] r_rs2   [2];
   logic [4:0]  r_ctrl  [2];
   logic        rsp_rdy [2];
   logic        din_ready;
   logic        dout_valid;
   logic [31:0] dout_rd;

   logic req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
   logic [4:0]  req0_ctrl, req1_ctrl;
   logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [31:0] rsp0_rd, rsp1_rd;
   logic unit_din_valid, unit_dout_ready;
   logic [31:0] unit_din_rs1, unit_din_rs2;
   logic [4:0]  unit_din_ctrl;
   logic [$clog2(DEPTH):0] inflight;
   logic proto_err;

   assign req0_valid = r_valid[0];
   assign req0_rs1   = r_rs1[0];
   assign req0_rs2   = r_rs2[0];
   assign req0_ctrl  = r_ctrl[0];
   assign req1_valid = r_valid[1];
   assign req1_rs1   = r_rs1[1];
   assign req1_rs2   = r_rs2[1];
   assign req1_ctrl  = r_ctrl[1];
   assign rsp0_ready = rsp_rdy[0];
   assign rsp1_ready = rsp_rdy[1];

   rvb_bextdep_arb #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clock           (clock),
      .reset           (reset),
      .req0_valid      (req0_valid),
      .req0_ready      (req0_ready),
      .req0_rs1        (req0_rs1),
      .req0_rs2        (req0_rs2),
      .req0_ctrl       (req0_ctrl),
      .req1_valid      (req1_valid),
      .req1_ready      (req1_ready),
      .req1_rs1        (req1_rs1),
      .req1_rs2        (req1_rs2),
      .req1_ctrl       (req1_ctrl),
      .rsp0_valid      (rsp0_valid),
      .rsp0_ready      (rsp0_ready),
      .rsp0_rd         (rsp0_rd),
      .rsp1_valid      (rsp1_valid),
      .rsp1_ready      (rsp1_ready),
      .rsp1_rd         (rsp1_rd),
      .unit_din_valid  (unit_din_valid),
      .unit_din_ready  (din_ready),
      .unit_din_rs1    (unit_din_rs1),
      .unit_din_rs2    (unit_din_rs2),
      .unit_din_ctrl   (unit_din_ctrl),
      .unit_dout_valid (dout_valid),
      .unit_dout_ready (unit_dout_ready),
      .unit_dout_rd    (dout_rd),
      .inflight        (inflight),
      .proto_err       (proto_err)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model: owner order of outstanding ops, per-port expected results, arbitration state.
   bit          tagq [$];
   logic [31:0] expq0 [$];
   logic [31:0] expq1 [$];
   uent_t       uq [$];
   bit          iss_seq [$];
   bit          m_fav, m_lock, m_lock_id, m_err;
   int          dlv [2];

   int unsigned p_req, p_din, p_rsp0, p_rsp1, lat_min, lat_max;
   int          ops_left [2];
   bit          inject;
   bit          adv0, adv1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] unit_op(input logic [31:0] a, input logic [31:0] m,
                                           input logic [4:0] c);
      logic [31:0] r;
      int j;
      r = '0;
      j = 0;
      for (int i = 0; i < 32; i++) begin
         if (m[i]) begin
            if (c[4]) r[i] = a[j];
            else      r[j] = a[i];
            j++;
         end
      end
      return r;
   endfunction

   task automatic gen_op(input int i);
      r_valid[i] = 1'b1;
      r_rs1[i]   = $urandom;
      r_rs2[i]   = $urandom;
      r_ctrl[i]  = ($urandom_range(1) == 1) ? CtrlBdep : CtrlBext;
   endtask

   // Sampled at negedge: compare, then advance the model to what the next edge commits.
   task automatic monitor();
      bit gid, gv, dv, pop_exp, id;
      logic [31:0] res;
      adv0 = 1'b0;
      adv1 = 1'b0;
      if (reset) begin
         check("reset_quiet", 64'({unit_din_valid, req0_ready, req1_ready, rsp0_valid,
                                   rsp1_valid, unit_dout_ready}), 64'd0);
         tagq.delete(); expq0.delete(); expq1.delete(); uq.delete();
         m_fav = 0; m_lock = 0; m_lock_id = 0; m_err = 0;
         return;
      end
      if (m_lock)                        gid = m_lock_id;
      else if (r_valid[0] && r_valid[1]) gid = m_fav;
      else                               gid = r_valid[1];
      gv = r_valid[gid];
      dv = gv && (tagq.size() < DEPTH);
      check("din_valid", 64'(unit_din_valid), 64'(dv));
      if (dv) begin
         check("din_rs1", 64'(unit_din_rs1), 64'(r_rs1[gid]));
         check("din_rs2", 64'(unit_din_rs2), 64'(r_rs2[gid]));
         check("din_ctrl", 64'(unit_din_ctrl), 64'(r_ctrl[gid]));
      end
      check("req0_ready", 64'(req0_ready), 64'(dv && din_ready && !gid));
      check("req1_ready", 64'(req1_ready), 64'(dv && din_ready && gid));
      check("inflight", 64'(inflight), 64'(tagq.size()));
      check("proto_err", 64'(proto_err), 64'(m_err));
      pop_exp = 1'b0;
      if (tagq.size() > 0) begin
         check("rsp0_valid", 64'(rsp0_valid), 64'(dout_valid && !tagq[0]));
         check("rsp1_valid", 64'(rsp1_valid), 64'(dout_valid && tagq[0]));
         check("dout_ready", 64'(unit_dout_ready), 64'(tagq[0] ? rsp_rdy[1] : rsp_rdy[0]));
         pop_exp = dout_valid && (tagq[0] ? rsp_rdy[1] : rsp_rdy[0]);
      end else begin
         check("empty_quiet", 64'({rsp0_valid, rsp1_valid, unit_dout_ready}), 64'd0);
         if (dout_valid) m_err = 1'b1;
      end
      if (pop_exp) begin
         id = tagq.pop_front();
         if (!id) begin
            check("rsp0_rd", 64'(rsp0_rd), 64'(expq0.pop_front()));
            dlv[0]++;
         end else begin
            check("rsp1_rd", 64'(rsp1_rd), 64'(expq1.pop_front()));
            dlv[1]++;
         end
      end
      if (dv && din_ready) begin
         tagq.push_back(gid);
         m_fav = !gid;
         res = unit_op(r_rs1[gid], r_rs2[gid], r_ctrl[gid]);
         if (gid) expq1.push_back(res);
         else     expq0.push_back(res);
      end
      m_lock    = dv && !din_ready;
      m_lock_id = gid;
      // The environment follows what the DUT actually did.
      if (dout_valid && unit_dout_ready && !inject && uq.size() > 0) void'(uq.pop_front());
      if (unit_din_valid && din_ready) begin
         uq.push_back('{unit_op(unit_din_rs1, unit_din_rs2, unit_din_ctrl),
                        cyc + int'($urandom_range(lat_max, lat_min))});
         iss_seq.push_back(req1_ready);
      end
      adv0 = r_valid[0] && req0_ready;
      adv1 = r_valid[1] && req1_ready;
   endtask

   task automatic update();
      cyc++;
      if (adv0) r_valid[0] = 1'b0;
      if (adv1) r_valid[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (!r_valid[i] && ops_left[i] > 0 && $urandom_range(99) < p_req) begin
            gen_op(i);
            ops_left[i]--;
         end
      end
      din_ready  = ($urandom_range(99) < p_din);
      rsp_rdy[0] = ($urandom_range(99) < p_rsp0);
      rsp_rdy[1] = ($urandom_range(99) < p_rsp1);
      dout_valid = inject || (uq.size() > 0 && uq[0].due <= cyc);
      dout_rd    = inject ? 32'hDEAD_BEEF : (uq.size() > 0 ? uq[0].data : 32'h0);
   endtask

   task automatic cycle();
      @(negedge clock);
      monitor();
      @(posedge clock);
      #1;
      update();
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (n < BOUND && !(ops_left[0] == 0 && ops_left[1] == 0 && !r_valid[0] && !r_valid[1]
                            && tagq.size() == 0 && uq.size() == 0)) begin
         cycle();
         n++;
      end
      check(tag, 64'(n < BOUND), 64'd1);
      check({tag, "_inflight"}, 64'(inflight), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         r_valid[i] = 0; r_rs1[i] = 0; r_rs2[i] = 0; r_ctrl[i] = 0; rsp_rdy[i] = 0;
         ops_left[i] = 0; dlv[i] = 0;
      end
      din_ready = 0; dout_valid = 0; dout_rd = 0; inject = 0;
      m_fav = 0; m_lock = 0; m_lock_id = 0; m_err = 0;
      p_req = 100; p_din = 100; p_rsp0 = 100; p_rsp1 = 100; lat_min = 1; lat_max = 1;

      reset = 1'b1;
      repeat (2) cycle();
      reset = 1'b0;
      check("rst_inflight", 64'(inflight), 64'd0);
      check("rst_proto_err", 64'(proto_err), 64'd0);

      // Both requesters saturating, unit always ready, 1-cycle latency.
      iss_seq.delete(); dlv[0] = 0; dlv[1] = 0;
      gen_op(0);
      r_rs1[0] = 32'h0000_00FF; r_rs2[0] = 32'h0F0F_0F0F; r_ctrl[0] = CtrlBdep;
      gen_op(1);
      ops_left[0] = 7; ops_left[1] = 7;
      wait_drain("alt_drain");
      check("alt_count", 64'(iss_seq.size()), 64'd16);
      for (int k = 0; k < iss_seq.size() && k < 16; k++)
         check("alt_seq", 64'(iss_seq[k]), 64'(k % 2));
      check("alt_dlv0", 64'(dlv[0]), 64'd8);
      check("alt_dlv1", 64'(dlv[1]), 64'd8);

      // Responses stalled: issue must stop at DEPTH.
      iss_seq.delete();
      p_rsp0 = 0; p_rsp1 = 0; rsp_rdy[0] = 0; rsp_rdy[1] = 0;
      ops_left[0] = 4; ops_left[1] = 4;
      repeat (12) cycle();
      check("stall_issues", 64'(iss_seq.size()), 64'(DEPTH));
      check("stall_inflight", 64'(inflight), 64'(DEPTH));
      check("stall_ready", 64'({req0_ready, req1_ready}), 64'd0);
      p_rsp0 = 100; p_rsp1 = 100;
      wait_drain("stall_drain");

      // Park the pointer on requester 1, then show the grant lock holding requester 0.
      ops_left[0] = 1;
      wait_drain("lock_prep");
      p_req = 0; p_din = 0; din_ready = 0;
      iss_seq.delete();
      gen_op(0);
      repeat (2) cycle();
      gen_op(1);
      repeat (3) cycle();
      p_din = 100;
      wait_drain("lock_drain");
      check("lock_count", 64'(iss_seq.size()), 64'd2);
      if (iss_seq.size() >= 2) begin
         check("lock_first", 64'(iss_seq[0]), 64'd0);
         check("lock_second", 64'(iss_seq[1]), 64'd1);
      end

      // Head-of-line blocking: requester 1 at the head, not ready.
      p_rsp0 = 100; p_rsp1 = 0; rsp_rdy[0] = 1; rsp_rdy[1] = 0;
      gen_op(1);
      cycle();
      gen_op(0);
      repeat (4) cycle();
      check("hol_inflight", 64'(inflight), 64'd2);
      check("hol_dout_ready", 64'(unit_dout_ready), 64'd0);
      check("hol_rsp0_valid", 64'(rsp0_valid), 64'd0);
      check("hol_rsp1_valid", 64'(rsp1_valid), 64'd1);
      p_rsp1 = 100;
      wait_drain("hol_drain");

      // Result with nothing outstanding.
      inject = 1; dout_valid = 1; dout_rd = 32'hDEAD_BEEF;
      cycle();
      inject = 0; dout_valid = 0; dout_rd = 0;
      check("proto_set", 64'(proto_err), 64'd1);
      repeat (3) cycle();
      check("proto_sticky", 64'(proto_err), 64'd1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("proto_cleared", 64'(proto_err), 64'd0);
      check("proto_inflight", 64'(inflight), 64'd0);

      // Reset with three ops outstanding, then a fresh op.
      p_req = 100; p_rsp0 = 0; p_rsp1 = 0; rsp_rdy[0] = 0; rsp_rdy[1] = 0;
      ops_left[0] = 2; ops_left[1] = 1;
      repeat (8) cycle();
      check("mid_inflight", 64'(inflight), 64'd3);
      reset = 1'b1;
      cycle();
      check("mid_rst_inflight", 64'(inflight), 64'd0);
      check("mid_rst_quiet", 64'({unit_din_valid, req0_ready, req1_ready, rsp0_valid,
                                  rsp1_valid, unit_dout_ready}), 64'd0);
      reset = 1'b0;
      p_rsp0 = 100; p_rsp1 = 100;
      dlv[0] = 0; dlv[1] = 0;
      ops_left[0] = 1;
      wait_drain("fresh_drain");
      check("fresh_dlv0", 64'(dlv[0]), 64'd1);

      // Random traffic with shifting knobs.
      lat_min = 1;
      for (int blk = 0; blk < 30; blk++) begin
         p_req   = $urandom_range(100, 30);
         p_din   = $urandom_range(100, 20);
         p_rsp0  = $urandom_range(100, 10);
         p_rsp1  = $urandom_range(100, 10);
         lat_max = $urandom_range(4, 1);
         ops_left[0] = 1000; ops_left[1] = 1000;
         repeat (100) cycle();
      end
      ops_left[0] = 0; ops_left[1] = 0;
      p_din = 100; p_rsp0 = 100; p_rsp1 = 100;
      wait_drain("rand_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
